// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, register IDs, icodes.
// Used by the pipeline stages and the pipeline registers.
package y86_pkg;

  // Status codes.
  localparam logic [3:0] SBUB = 4'h0;
  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  // Register IDs.
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int unsigned NumRegs = 15;

  // Instruction codes.
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Any status code above INS is an invalid-instruction exception.
  function automatic logic [3:0] stat_norm(input logic [3:0] s);
    return (s > SINS) ? SINS : s;
  endfunction

endpackage

// File: rtl/y86_regarray.sv
// 15 x 64 program register array.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   we_i                    write enable shared by both write ports
//   dst_e_i/val_e_i         E write port (RNONE = no write)
//   dst_m_i/val_m_i         M write port (RNONE = no write), wins over E
//   src_a_i/src_b_i         decode read addresses
//   dbg_addr_i              debug read address
//   rval_a_o/rval_b_o       combinational read data (RNONE reads 0)
//   dbg_data_o              combinational debug read data
module y86_regarray
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  dst_e_i,
  input  logic [63:0] val_e_i,
  input  logic [3:0]  dst_m_i,
  input  logic [63:0] val_m_i,
  input  logic [3:0]  src_a_i,
  input  logic [3:0]  src_b_i,
  input  logic [3:0]  dbg_addr_i,
  output logic [63:0] rval_a_o,
  output logic [63:0] rval_b_o,
  output logic [63:0] dbg_data_o
);

  logic [63:0] regs_q [NumRegs];
  logic [63:0] regs_d [NumRegs];

  // M is applied after E so that popq %rsp leaves the popped value in %rsp.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we_i && (dst_e_i != RNONE)) begin
      regs_d[dst_e_i] = val_e_i;
    end
    if (we_i && (dst_m_i != RNONE)) begin
      regs_d[dst_m_i] = val_m_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'h0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write-to-read bypass: decode forwarding handles same-cycle hazards.
  always_comb begin
    rval_a_o   = (src_a_i    == RNONE) ? 64'h0 : regs_q[src_a_i];
    rval_b_o   = (src_b_i    == RNONE) ? 64'h0 : regs_q[src_b_i];
    dbg_data_o = (dbg_addr_i == RNONE) ? 64'h0 : regs_q[dbg_addr_i];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Commits W-stage results into the register array, latches the sticky halt
// status, and counts cycles and retired instructions.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   W_stat, W_icode               status / icode of the writeback instruction
//   W_dstE/W_valE, W_dstM/W_valM  write ports (4'hF = none), M wins on collision
//   d_srcA/d_srcB -> d_rvalA/B    combinational decode reads
//   dbg_addr -> dbg_data          combinational debug read
//   proc_stat, halted             architectural status, sticky halt flag
//   cycle_cnt, retired_cnt        CNT_W-bit wrapping counters
module wb_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  input  logic [3:0]       dbg_addr,
  output logic [63:0]      dbg_data,
  output logic [3:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             halted_q, halted_d;
  logic [3:0]       proc_stat_q, proc_stat_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             commit;
  logic             halt_evt;

  always_comb begin
    commit      = (W_stat == SAOK) && !halted_q;
    // HLT, ADR, INS and every undefined code above INS stop the machine.
    halt_evt    = !halted_q && (W_stat >= SHLT);
    halted_d    = halted_q;
    proc_stat_d = proc_stat_q;
    cycle_d     = cycle_q;
    retired_d   = retired_q;
    if (halt_evt) begin
      halted_d    = 1'b1;
      proc_stat_d = stat_norm(W_stat);
    end
    // The edge that sets halted still counts as an executed cycle.
    if (!halted_q) begin
      cycle_d = cycle_q + CntOne;
    end
    if (commit && (W_icode != INOP)) begin
      retired_d = retired_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q    <= 1'b0;
      proc_stat_q <= SAOK;
      cycle_q     <= '0;
      retired_q   <= '0;
    end else begin
      halted_q    <= halted_d;
      proc_stat_q <= proc_stat_d;
      cycle_q     <= cycle_d;
      retired_q   <= retired_d;
    end
  end

  y86_regarray #(
    .RSP_INIT (RSP_INIT)
  ) u_regarray (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (commit),
    .dst_e_i    (W_dstE),
    .val_e_i    (W_valE),
    .dst_m_i    (W_dstM),
    .val_m_i    (W_valM),
    .src_a_i    (d_srcA),
    .src_b_i    (d_srcB),
    .dbg_addr_i (dbg_addr),
    .rval_a_o   (d_rvalA),
    .rval_b_o   (d_rvalB),
    .dbg_data_o (dbg_data)
  );

  assign proc_stat   = proc_stat_q;
  assign halted      = halted_q;
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
`timescale 1ns/100ps
module tb_wb_regfile;

  localparam logic [63:0] RspInit = 64'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  W_stat = 4'h0, W_icode = 4'h0, W_dstE = 4'hF, W_dstM = 4'hF;
  logic [63:0] W_valE = '0, W_valM = '0;
  logic [3:0]  d_srcA = 4'hF, d_srcB = 4'hF, dbg_addr = 4'hF;
  logic [63:0] d_rvalA, d_rvalB, dbg_data;
  logic [3:0]  proc_stat;
  logic        halted;
  logic [63:0] cycle_cnt, retired_cnt;
  // Second instance with 4-bit counters to exercise wrap-around.
  logic [63:0] w_rvalA, w_rvalB, w_dbg;
  logic [3:0]  w_pstat;
  logic        w_halted;
  logic [3:0]  w_cyc, w_ret;

  always #5 clk = ~clk;

  wb_regfile #(.RSP_INIT(RspInit), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .proc_stat(proc_stat),
    .halted(halted), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  wb_regfile #(.RSP_INIT(RspInit), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(w_rvalA), .d_rvalB(w_rvalB),
    .dbg_addr(dbg_addr), .dbg_data(w_dbg), .proc_stat(w_pstat),
    .halted(w_halted), .cycle_cnt(w_cyc), .retired_cnt(w_ret)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural state as plain variables.
  logic [63:0] m_regs [15];
  logic        m_halted;
  logic [3:0]  m_pstat;
  logic [63:0] m_cyc, m_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] a);
    return (a == 4'hF) ? 64'h0 : m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? RspInit : 64'h0;
    m_halted = 1'b0;
    m_pstat  = 4'h1;
    m_cyc    = '0;
    m_ret    = '0;
  endtask

  task automatic model_step(input logic [3:0] st, input logic [3:0] ic,
                            input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm);
    if (!m_halted) begin
      m_cyc++;
      if (st == 4'h1) begin
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;
        if (ic != 4'h1) m_ret++;
      end else if (st != 4'h0) begin
        m_halted = 1'b1;
        m_pstat  = (st > 4'h4) ? 4'h4 : st;
      end
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    W_stat = st; W_icode = ic; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
  endtask

  task automatic cycle_step(input logic [3:0] st, input logic [3:0] ic,
                            input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm);
    drive(st, ic, de, ve, dm, vm);
    @(posedge clk);
    #1;
    model_step(st, ic, de, ve, dm, vm);
  endtask

  task automatic check_all(input string tag);
    logic [3:0] a, b, d;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    d = 4'($urandom_range(0, 15));
    d_srcA = a; d_srcB = b; dbg_addr = d;
    #0.2;
    chk({tag, ".rvalA"}, d_rvalA, m_read(a));
    chk({tag, ".rvalB"}, d_rvalB, m_read(b));
    chk({tag, ".dbg"}, dbg_data, m_read(d));
    chk({tag, ".w_rvalA"}, w_rvalA, m_read(a));
    chk({tag, ".pstat"}, 64'(proc_stat), 64'(m_pstat));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
    chk({tag, ".cycle"}, cycle_cnt, m_cyc);
    chk({tag, ".retired"}, retired_cnt, m_ret);
    chk({tag, ".w_cycle"}, 64'(w_cyc), 64'(m_cyc[3:0]));
    chk({tag, ".w_retired"}, 64'(w_ret), 64'(m_ret[3:0]));
  endtask

  typedef struct {
    logic [3:0]  stat, icode, dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
    logic [3:0]  src_a, src_b;
    logic [63:0] exp_a, exp_b;
    logic [3:0]  exp_pstat;
    logic        exp_halted;
    logic [63:0] exp_cyc, exp_ret;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // stat icode dE valE dM valM srcA srcB | expA expB pstat halted cyc ret
    vecs[0] = '{4'h1, 4'h2, 4'h0, 64'hDEAD, 4'hF, 64'h0, 4'h0, 4'hF,
                64'hDEAD, 64'h0, 4'h1, 1'b0, 64'd1, 64'd1};
    vecs[1] = '{4'h1, 4'hB, 4'h4, 64'h108, 4'h4, 64'h55, 4'h4, 4'h0,
                64'h55, 64'hDEAD, 4'h1, 1'b0, 64'd2, 64'd2};
    vecs[2] = '{4'h1, 4'h6, 4'h3, 64'h7, 4'h5, 64'h9, 4'h3, 4'h5,
                64'h7, 64'h9, 4'h1, 1'b0, 64'd3, 64'd3};
    vecs[3] = '{4'h0, 4'h0, 4'h3, 64'hFF, 4'h5, 64'hEE, 4'h3, 4'h5,
                64'h7, 64'h9, 4'h1, 1'b0, 64'd4, 64'd3};
    vecs[4] = '{4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 4'h3,
                64'h55, 64'h7, 4'h1, 1'b0, 64'd5, 64'd3};
    vecs[5] = '{4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 4'h3,
                64'h55, 64'h7, 4'h1, 1'b0, 64'd6, 64'd3};
    vecs[6] = '{4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 4'h3,
                64'h55, 64'h7, 4'h1, 1'b0, 64'd7, 64'd3};
    vecs[7] = '{4'h3, 4'h5, 4'hF, 64'h0, 4'h2, 64'h1, 4'h2, 4'h4,
                64'h0, 64'h55, 4'h3, 1'b1, 64'd8, 64'd3};
    vecs[8] = '{4'h1, 4'h2, 4'h2, 64'h77, 4'hF, 64'h0, 4'h2, 4'h0,
                64'h0, 64'hDEAD, 4'h3, 1'b1, 64'd8, 64'd3};
    vecs[9] = '{4'h2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h5, 4'h3,
                64'h9, 64'h7, 4'h3, 1'b1, 64'd8, 64'd3};

    #1 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();

    // Directed table.
    foreach (vecs[i]) begin
      d_srcA = vecs[i].src_a;
      d_srcB = vecs[i].src_b;
      cycle_step(vecs[i].stat, vecs[i].icode, vecs[i].dst_e, vecs[i].val_e,
                 vecs[i].dst_m, vecs[i].val_m);
      chk($sformatf("vec%0d.rvalA", i), d_rvalA, vecs[i].exp_a);
      chk($sformatf("vec%0d.rvalB", i), d_rvalB, vecs[i].exp_b);
      chk($sformatf("vec%0d.pstat", i), 64'(proc_stat), 64'(vecs[i].exp_pstat));
      chk($sformatf("vec%0d.halted", i), 64'(halted), 64'(vecs[i].exp_halted));
      chk($sformatf("vec%0d.cycle", i), cycle_cnt, vecs[i].exp_cyc);
      chk($sformatf("vec%0d.retired", i), retired_cnt, vecs[i].exp_ret);
      chk($sformatf("vec%0d.w_cycle", i), 64'(w_cyc), 64'(vecs[i].exp_cyc[3:0]));
    end

    // Mid-cycle reset from a halted, dirty state; checked before any edge.
    rst = 1'b1;
    model_reset();
    #0.2;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      d_srcA   = 4'(15 - i);
      #0.2;
      chk($sformatf("rst.dbg%0d", i), dbg_data, (i == 4) ? 64'h100 : 64'h0);
      chk($sformatf("rst.rvalA%0d", 15 - i), d_rvalA, (i == 11) ? 64'h100 : 64'h0);
    end
    chk("rst.pstat", 64'(proc_stat), 64'h1);
    chk("rst.halted", 64'(halted), 64'h0);
    chk("rst.cycle", cycle_cnt, 64'h0);
    chk("rst.retired", retired_cnt, 64'h0);
    rst = 1'b0;

    // 16 bubbles: narrow counter wraps to 0, wide one reaches 16.
    for (int i = 0; i < 16; i++) begin
      cycle_step(4'h0, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
      if (i == 14) chk("wrap.w_cycle15", 64'(w_cyc), 64'd15);
    end
    chk("wrap.w_cycle", 64'(w_cyc), 64'h0);
    chk("wrap.cycle", cycle_cnt, 64'd16);
    // Undefined status 9 halts as INS.
    cycle_step(4'h9, 4'h3, 4'h1, 64'h5, 4'hF, 64'h0);
    check_all("ins");
    chk("ins.pstat", 64'(proc_stat), 64'h4);
    // Reset while halted.
    rst = 1'b1;
    model_reset();
    #1;
    chk("rsth.halted", 64'(halted), 64'h0);
    chk("rsth.pstat", 64'(proc_stat), 64'h1);
    chk("rsth.w_pstat", 64'(w_pstat), 64'h1);
    chk("rsth.rsp", w_dbg, (dbg_addr == 4'h4) ? 64'h100 : m_read(dbg_addr));
    rst = 1'b0;

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] st, ic, de, dm;
      int unsigned r;
      if ($urandom_range(0, m_halted ? 7 : 60) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        rst = 1'b0;
      end else begin
        r  = $urandom_range(0, 99);
        st = (r < 82) ? 4'h1 : (r < 90) ? 4'h0 : 4'($urandom_range(2, 15));
        ic = 4'($urandom_range(0, 11));
        de = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        dm = ($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 15));
        cycle_step(st, ic, de, {$urandom, $urandom}, dm, {$urandom, $urandom});
        check_all($sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
